fifo_write_arbiter: RTL

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
// Two-port write arbiter in front of a FIFO. Accepts held requests from a
// host loader (port 0) and a CPU (port 1), issues registered write strobes,
// tracks FIFO occupancy from writes and consumer advances, and turns flush
// into a registered FIFO reset.
module fifo_write_arbiter #(
   parameter int unsigned DATA_W   = 12,
   parameter int unsigned FILL_MAX = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_i,
   input  logic [DATA_W-1:0] data0_i,
   input  logic              req1_i,
   input  logic [DATA_W-1:0] data1_i,
   input  logic              prio_mode_i,
   input  logic              flush_i,
   input  logic              fifo_adv_i,
   output logic              ack0_o,
   output logic              ack1_o,
   output logic              fifo_write_o,
   output logic [DATA_W-1:0] fifo_data_o,
   output logic              fifo_rst_o,
   output logic [7:0]        fill_o,
   output logic              full_o,
   output logic              empty_o
);

   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic              fifo_write_q, fifo_write_d;
   logic [DATA_W-1:0] fifo_data_q, fifo_data_d;
   logic              fifo_rst_q, fifo_rst_d;
   logic [7:0]        fill_q, fill_d;
   // 1 = port 1 was granted last, so port 0 wins the next tie in round-robin.
   logic              last_q, last_d;

   logic [8:0] occupied;
   logic       room;
   logic       blocked;
   logic       elig0, elig1;
   logic       grant0, grant1;
   logic       fill_dec;

   // The write still in flight counts against capacity; reads are not credited.
   assign occupied = {1'b0, fill_q} + {8'd0, fifo_write_q};
   assign room     = occupied < 9'(FILL_MAX);
   assign blocked  = flush_i | fifo_rst_q;
   // ack_q=1 means the held request was just accepted; skip it this edge.
   assign elig0    = req0_i & ~ack0_q & ~blocked & room;
   assign elig1    = req1_i & ~ack1_q & ~blocked & room;
   assign fill_dec = fifo_adv_i & (fill_q != 8'd0);

   // Pick at most one winner: fixed priority to port 0, or alternate on a tie.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (elig0 && elig1) begin
         if (prio_mode_i || last_q) begin
            grant0 = 1'b1;
         end else begin
            grant1 = 1'b1;
         end
      end else begin
         grant0 = elig0;
         grant1 = elig1;
      end
   end

   // Next-state for the write port, acks, grant pointer and FIFO reset.
   always_comb begin
      ack0_d       = grant0;
      ack1_d       = grant1;
      fifo_write_d = grant0 | grant1;
      fifo_data_d  = fifo_data_q;
      last_d       = last_q;
      fifo_rst_d   = flush_i;
      if (grant0) begin
         fifo_data_d = data0_i;
         last_d      = 1'b0;
      end else if (grant1) begin
         fifo_data_d = data1_i;
         last_d      = 1'b1;
      end
   end

   // Occupancy: cleared while the FIFO is being reset, otherwise +write -read.
   always_comb begin
      fill_d = fill_q;
      if (blocked) begin
         fill_d = 8'd0;
      end else if (fifo_write_q && !fill_dec) begin
         fill_d = fill_q + 8'd1;
      end else if (!fifo_write_q && fill_dec) begin
         fill_d = fill_q - 8'd1;
      end
   end

   // State registers with synchronous reset; reset drops any pending grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         fifo_write_q <= 1'b0;
         fifo_data_q  <= '0;
         fifo_rst_q   <= 1'b1;
         fill_q       <= 8'd0;
         last_q       <= 1'b1;
      end else begin
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         fifo_write_q <= fifo_write_d;
         fifo_data_q  <= fifo_data_d;
         fifo_rst_q   <= fifo_rst_d;
         fill_q       <= fill_d;
         last_q       <= last_d;
      end
   end

   assign ack0_o       = ack0_q;
   assign ack1_o       = ack1_q;
   assign fifo_write_o = fifo_write_q;
   assign fifo_data_o  = fifo_data_q;
   assign fifo_rst_o   = fifo_rst_q;
   assign fill_o       = fill_q;
   assign full_o       = (fill_q == 8'(FILL_MAX));
   assign empty_o      = (fill_q == 8'd0);

endmodule
